// File: rtl/broadcast_filter_scheduler.sv
// Round-robin scheduler sharing the broadcast probe-filter lookup port among MSHR trackers.
// Allows one outstanding lookup per tracker and steers filter responses back by mshr tag.
module broadcast_filter_scheduler #(
    parameter int N_TRACKERS = 4,
    parameter int MSHR_W     = 2,
    parameter int ADDR_W     = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_TRACKERS-1:0]        io_in_valid,
    output logic [N_TRACKERS-1:0]        io_in_ready,
    input  logic [N_TRACKERS*ADDR_W-1:0] io_in_address,
    input  logic [N_TRACKERS-1:0]        io_in_allocOH,
    input  logic [N_TRACKERS-1:0]        io_in_needT,
    output logic                         io_filter_req_valid,
    input  logic                         io_filter_req_ready,
    output logic [MSHR_W-1:0]            io_filter_req_mshr,
    output logic [ADDR_W-1:0]            io_filter_req_address,
    output logic                         io_filter_req_allocOH,
    output logic                         io_filter_req_needT,
    input  logic                         io_filter_resp_valid,
    output logic                         io_filter_resp_ready,
    input  logic [MSHR_W-1:0]            io_filter_resp_mshr,
    input  logic                         io_filter_resp_needT,
    output logic [N_TRACKERS-1:0]        io_out_valid,
    input  logic [N_TRACKERS-1:0]        io_out_ready,
    output logic                         io_out_needT,
    output logic [MSHR_W:0]              io_inflight,
    output logic                         io_error
);

    function automatic logic [MSHR_W:0] popcount(input logic [N_TRACKERS-1:0] v);
        logic [MSHR_W:0] c;
        c = {(MSHR_W+1){1'b0}};
        for (int i = 0; i < N_TRACKERS; i++) begin
            c = c + {{MSHR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [N_TRACKERS-1:0] busy_r;
    logic [N_TRACKERS-1:0] busy_next_s;
    logic [N_TRACKERS-1:0] elig_s;
    logic [N_TRACKERS-1:0] grant_s;
    logic [N_TRACKERS-1:0] clr_s;
    logic [MSHR_W-1:0]     rr_ptr_r;
    logic [MSHR_W-1:0]     grant_idx_s;
    logic                  grant_any_s;
    logic                  loadable_s;
    logic                  resp_fire_s;
    logic                  resp_err_s;
    logic                  req_valid_r;
    logic [MSHR_W-1:0]     req_mshr_r;
    logic [ADDR_W-1:0]     req_address_r;
    logic                  req_allocoh_r;
    logic                  req_needt_r;
    logic [MSHR_W:0]       inflight_r;
    logic                  error_r;

    // Round-robin pick of the first eligible tracker starting at rr_ptr; no grant while in reset.
    always_comb begin
        logic [MSHR_W-1:0] idx;
        logic              hit;
        elig_s      = io_in_valid & ~busy_r;
        loadable_s  = ~req_valid_r | io_filter_req_ready;
        grant_s     = {N_TRACKERS{1'b0}};
        grant_idx_s = {MSHR_W{1'b0}};
        grant_any_s = 1'b0;
        for (int k = 0; k < N_TRACKERS; k++) begin
            idx          = rr_ptr_r + MSHR_W'(k);
            hit          = elig_s[idx] & ~grant_any_s & loadable_s & ~reset;
            grant_s[idx] = grant_s[idx] | hit;
            grant_idx_s  = hit ? idx : grant_idx_s;
            grant_any_s  = grant_any_s | hit;
        end
    end

    // Zero-latency response steering and busy-set update bookkeeping.
    always_comb begin
        for (int i = 0; i < N_TRACKERS; i++) begin
            io_out_valid[i] = io_filter_resp_valid & (io_filter_resp_mshr == MSHR_W'(i)) & ~reset;
        end
        io_filter_resp_ready = io_out_ready[io_filter_resp_mshr] & ~reset;
        resp_fire_s          = io_filter_resp_valid & io_filter_resp_ready;
        clr_s                = {N_TRACKERS{1'b0}};
        clr_s[io_filter_resp_mshr] = resp_fire_s;
        resp_err_s           = resp_fire_s & ~busy_r[io_filter_resp_mshr];
        // Grant wins over a stray clear so a same-cycle error response cannot drop a new lookup.
        busy_next_s          = (busy_r & ~clr_s) | grant_s;
    end

    // Request register, busy tracking, round-robin pointer and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_valid_r   <= 1'b0;
            req_mshr_r    <= {MSHR_W{1'b0}};
            req_address_r <= {ADDR_W{1'b0}};
            req_allocoh_r <= 1'b0;
            req_needt_r   <= 1'b0;
            busy_r        <= {N_TRACKERS{1'b0}};
            rr_ptr_r      <= {MSHR_W{1'b0}};
            inflight_r    <= {(MSHR_W+1){1'b0}};
            error_r       <= 1'b0;
        end else begin
            if (loadable_s) begin
                req_valid_r <= grant_any_s;
            end
            if (grant_any_s) begin
                req_mshr_r    <= grant_idx_s;
                req_address_r <= io_in_address[grant_idx_s*ADDR_W +: ADDR_W];
                req_allocoh_r <= io_in_allocOH[grant_idx_s];
                req_needt_r   <= io_in_needT[grant_idx_s];
                rr_ptr_r      <= grant_idx_s + MSHR_W'(1);
            end
            busy_r     <= busy_next_s;
            inflight_r <= popcount(busy_next_s);
            if (resp_err_s) begin
                error_r <= 1'b1;
            end
        end
    end

    assign io_in_ready           = grant_s;
    assign io_filter_req_valid   = req_valid_r;
    assign io_filter_req_mshr    = req_mshr_r;
    assign io_filter_req_address = req_address_r;
    assign io_filter_req_allocOH = req_allocoh_r;
    assign io_filter_req_needT   = req_needt_r;
    assign io_out_needT          = io_filter_resp_needT;
    assign io_inflight           = inflight_r;
    assign io_error              = error_r;

endmodule
